// File: rtl/mem_pkg.sv
// Shared encodings for the CPU-to-RAM access controller: request sizes,
// controller states and byte-lane geometry.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_chk.sv
// Protocol checker for the RAM control strobes driven by mem_access_ctrl.
module mem_access_ctrl_chk (
  input logic clk,
  input logic ram_cs,
  input logic ram_we,
  input logic ram_oe
);

  a_we_oe_excl: assert property (@(posedge clk) !(ram_we && ram_oe));
  a_cs_covers:  assert property (@(posedge clk) (ram_we || ram_oe) |-> ram_cs);

endmodule

// File: rtl/mem_lane_unit.sv
// Byte-lane datapath: extract/extend/rotate a RAM word for loads and merge
// sub-word store data into a RAM word. Purely combinational.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt_s;
  logic [4:0]  shamt_h_s;
  logic [31:0] rot_s;

  assign shamt_s   = {lane, 3'b000};
  assign shamt_h_s = {lane[1], 4'b0000};
  // Rotating right by the lane offset puts lane k in the low byte, which also serves byte/half extraction.
  assign rot_s     = 32'({rdata, rdata} >> shamt_s);

  // Load result: lane extraction with optional sign extension, or rotated word.
  always_comb begin
    load_data = 32'h0000_0000;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & rot_s[7]}}, rot_s[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & rot_s[15]}}, rot_s[15:0]};
      SZ_WORD: load_data = rot_s;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: replace the addressed lane(s), keep the rest from RAM.
  always_comb begin
    merge_data = rdata;
    case (size)
      SZ_BYTE: merge_data[shamt_s +: LANE_W]       = wdata[7:0];
      SZ_HALF: merge_data[shamt_h_s +: 2 * LANE_W] = wdata[15:0];
      SZ_WORD: merge_data = wdata;
      default: merge_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU memory stage and a single-port word RAM.
// Sub-word stores use read-modify-write; misaligned word loads rotate (ARMv4 LDR).
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     ram_address,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic                      ram_oe
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("mem_access_ctrl: DATA_WIDTH must be 32");
    end
  endgenerate

  state_t                    state_r;
  state_t                    next_s;
  logic                      write_r;
  logic                      sign_r;
  logic [1:0]                size_r;
  logic [1:0]                lane_r;
  logic [31:0]               wdata_r;
  logic                      accept_s;
  logic                      err_s;
  logic [CPU_ADDR_WIDTH-1:0] addr_hi_s;
  logic [31:0]               load_s;
  logic [31:0]               merge_s;

  assign accept_s  = req_valid && req_ready;
  assign addr_hi_s = req_addr >> (ADDR_WIDTH + 2);
  assign err_s     = (req_size == SZ_ILL) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     (addr_hi_s != {CPU_ADDR_WIDTH{1'b0}});

  mem_lane_unit u_lane (
    .size       (size_r),
    .sign_ext   (sign_r),
    .lane       (lane_r),
    .rdata      (ram_rdata),
    .wdata      (wdata_r),
    .load_data  (load_s),
    .merge_data (merge_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_s;
  end

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (err_s)                                  next_s = ST_RESP;
          else if (req_write && req_size == SZ_WORD)  next_s = ST_WRITE;
          else                                        next_s = ST_RD_ADDR;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RD_ADDR: next_s = ST_RD_DATA;
      ST_RD_DATA: begin
        if (write_r) next_s = ST_WRITE;
        else         next_s = ST_RESP;
      end
      ST_WRITE: next_s = ST_RESP;
      ST_RESP:  next_s = ST_IDLE;
      default:  next_s = ST_IDLE;
    endcase
  end

  // Request capture on accept; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_r <= 1'b0;
      sign_r  <= 1'b0;
      size_r  <= SZ_BYTE;
      lane_r  <= 2'b00;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      write_r <= req_write;
      sign_r  <= req_signed;
      size_r  <= req_size;
      lane_r  <= req_addr[1:0];
      wdata_r <= req_wdata;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0000_0000;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_address <= {ADDR_WIDTH{1'b0}};
      ram_wdata   <= 32'h0000_0000;
    end else begin
      req_ready <= (next_s == ST_IDLE);
      rsp_valid <= (next_s == ST_RESP);
      // Only a rejected request goes straight from IDLE to RESP.
      rsp_err   <= (next_s == ST_RESP) && (state_r == ST_IDLE);
      rsp_rdata <= (state_r == ST_RD_DATA && !write_r) ? load_s : 32'h0000_0000;
      ram_cs    <= (next_s == ST_RD_ADDR) || (next_s == ST_RD_DATA) || (next_s == ST_WRITE);
      ram_oe    <= (next_s == ST_RD_ADDR) || (next_s == ST_RD_DATA);
      ram_we    <= (next_s == ST_WRITE);
      if (accept_s && !err_s) begin
        ram_address <= req_addr[ADDR_WIDTH+1:2];
        ram_wdata   <= req_wdata;
      end else if (state_r == ST_RD_DATA && write_r) begin
        ram_wdata <= merge_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural single-port word RAM.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  ram_address;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_cs, ram_we, ram_oe;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WIDTH(10), .CPU_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  mem_access_ctrl_chk u_chk (.clk(clk), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe));

  // Single-port synchronous RAM: registered read, output driven only while reading.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_address] <= ram_wdata;
    if (ram_cs && ram_oe && !ram_we) rd_q <= mem[ram_address];
  end
  assign ram_rdata = (ram_cs && ram_oe && !ram_we) ? rd_q : 32'h0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rsp = -1;
  int   cs_cnt = 0;
  int   we_cnt = 0;
  bit   b2b = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: accept timestamps, response scoring, strobe counting.
  always @(posedge clk) begin
    exp_t e;
    int   a;
    cyc = cyc + 1;
    if (ram_cs) cs_cnt++;
    if (ram_we) we_cnt++;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (b2b) check("ready_while_busy", {31'b0, req_ready && (ram_cs || rsp_valid)}, 32'h0);
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        if (b2b && last_rsp >= 0) check("b2b_accept_gap", cyc - last_rsp, 32'd1);
      end
      if (rsp_valid) begin
        check("rsp_expected", {31'b0, sb.size() != 0 && acc_q.size() != 0}, 32'h1);
        if (sb.size() != 0 && acc_q.size() != 0) begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          check({e.name, ".rdata"}, rsp_rdata, e.rdata);
          check({e.name, ".err"}, {31'b0, rsp_err}, {31'b0, e.err});
          check({e.name, ".lat"}, cyc - a, e.lat);
        end
        last_rsp = cyc;
      end
    end
  end

  task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int el, input bit push);
    exp_t e;
    bit   done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    if (push) begin
      e.name = name; e.rdata = er; e.err = ee; e.lat = el;
      sb.push_back(e);
    end
    for (int n = 0; n < 50; n++) begin
      if (req_ready) begin
        @(posedge clk);
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check({name, ".accept_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check("drain_empty", sb.size(), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cs_snap, we_snap;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", {31'b0, req_ready}, 32'h1);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.ram_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'h0);
    check("rst.ram_address", {22'b0, ram_address}, 32'h0);
    check("rst.ram_wdata", ram_wdata, 32'h0);
    rst = 1'b0;

    // name, write, size, signed, addr, wdata, exp rdata, exp err, latency
    do_req("str_100",   1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1); drain();
    do_req("ldr_100",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1); drain();
    do_req("ldr_102",   1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hBEEFDEAD, 1'b0, 3, 1'b1); drain();
    do_req("ldr_101",   1'b0, 2'b10, 1'b1, 32'h101, 32'h0, 32'hEFDEADBE, 1'b0, 3, 1'b1); drain();
    do_req("ldr_103",   1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 32'hADBEEFDE, 1'b0, 3, 1'b1); drain();
    do_req("ldrh_102",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 3, 1'b1); drain();
    do_req("ldrsh_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 1'b1); drain();
    do_req("ldrb_102",  1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 32'h000000AD, 1'b0, 3, 1'b1); drain();
    do_req("ldrsb_102", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'hFFFFFFAD, 1'b0, 3, 1'b1); drain();
    do_req("strb_101",  1'b1, 2'b00, 1'b0, 32'h101, 32'hAAAAAA55, 32'h0, 1'b0, 4, 1'b1); drain();
    do_req("ldr_100b",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD55EF, 1'b0, 3, 1'b1); drain();
    do_req("ldrsb_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h00000055, 1'b0, 3, 1'b1); drain();
    do_req("ldrsb_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 3, 1'b1); drain();
    do_req("strh_202",  1'b1, 2'b01, 1'b1, 32'h202, 32'hFFFF1234, 32'h0, 1'b0, 4, 1'b1); drain();
    do_req("strb_203",  1'b1, 2'b00, 1'b0, 32'h203, 32'h00000080, 32'h0, 1'b0, 4, 1'b1); drain();
    do_req("ldr_200",   1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h80340000, 1'b0, 3, 1'b1); drain();
    do_req("ldrsh_200", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h00000000, 1'b0, 3, 1'b1); drain();
    do_req("ldrsb_203", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1); drain();
    do_req("str_303",   1'b1, 2'b10, 1'b0, 32'h303, 32'h11223344, 32'h0, 1'b0, 2, 1'b1); drain();
    do_req("ldr_300",   1'b0, 2'b10, 1'b1, 32'h300, 32'h0, 32'h11223344, 1'b0, 3, 1'b1); drain();

    cs_snap = cs_cnt;
    do_req("err_ldrh_101", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1); drain();
    do_req("err_addr_1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b1); drain();
    do_req("err_size_11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1); drain();
    do_req("err_strh_103", 1'b1, 2'b01, 1'b0, 32'h103, 32'h0000FFFF, 32'h0, 1'b1, 1, 1'b1); drain();
    do_req("err_str_hi", 1'b1, 2'b10, 1'b0, 32'h80000100, 32'h12345678, 32'h0, 1'b1, 1, 1'b1); drain();
    check("err.no_cs", cs_cnt - cs_snap, 32'h0);
    do_req("ldr_100c", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD55EF, 1'b0, 3, 1'b1); drain();

    // Reset while a halfword store is in RD_DATA, with a request held during reset.
    we_snap = we_cnt;
    do_req("strh_abort", 1'b1, 2'b01, 1'b0, 32'h100, 32'h00001234, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("abort.in_read", {31'b0, ram_oe}, 32'h1);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h100;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("abort.ready", {31'b0, req_ready}, 32'h1);
    check("abort.ram_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'h0);
    repeat (6) @(negedge clk);
    check("abort.no_we", we_cnt - we_snap, 32'h0);
    check("abort.mem", mem[10'h040], 32'hDEAD55EF);
    do_req("ldr_after_abort", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD55EF, 1'b0, 3, 1'b1); drain();

    // Back-to-back with req_valid held high.
    last_rsp = -1;
    b2b = 1'b1;
    do_req("b2b_ldr",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD55EF, 1'b0, 3, 1'b1);
    do_req("b2b_ldrsb", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 3, 1'b1);
    do_req("b2b_err",   1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    do_req("b2b_str",   1'b1, 2'b10, 1'b0, 32'h304, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1'b1);
    do_req("b2b_strh",  1'b1, 2'b01, 1'b0, 32'h306, 32'h00005A5A, 32'h0, 1'b0, 4, 1'b1);
    do_req("b2b_ld304", 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h5A5AA5A5, 1'b0, 3, 1'b1);
    drain();
    b2b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
